io_out_buf: RTL
===============

Name: io_out_buf

Overview:
- Output-port buffer directly downstream of the fixed-point processor core.
- Captures every OUT write (out_en, addr_out, data_out) into a small FIFO.
- Presents each write to external peripherals over a valid/ready stream, so slow consumers do not lose data.
- The core cannot stall, so overflow is dropped and flagged.

Parameters:
- NUBITS, 32: data word width; equals the core's NUBITS.
- NUIOOU, 8: number of output addresses; equals the core's NUIOOU.
- FDEPTH, 8: FIFO storage entries, excluding the output stage; power of 2, ≥2.
- AW (localparam), (NUIOOU>1) ? $clog2(NUIOOU) : 1: address width.
- LW (localparam), $clog2(FDEPTH+2): occupancy counter width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- out_en  in  1  core OUT strobe; one write per high cycle
- addr_out  in  AW  core output address; ignored (treated as 0) when NUIOOU==1
- data_out  in  NUBITS  core output word; valid when out_en=1
- o_valid  out  1  output stage holds an entry
- o_ready  in  1  consumer accepts the entry this cycle
- o_addr  out  AW  address of the presented entry
- o_data  out  NUBITS  data of the presented entry
- level  out  LW  entries held, FIFO plus output stage, range 0..FDEPTH+1
- full  out  1  level == FDEPTH+1
- ovf  out  1  sticky overflow flag
- ovf_clr  in  1  synchronous clear of ovf

Behaviour:
- Reset (async, rst high):
  - o_valid=0, o_addr=0, o_data=0, level=0, full=0, ovf=0.
  - FIFO pointers cleared; storage contents don't-care.
  - Reset mid-stream discards all entries; no partial transfer survives.
- Entry = {addr, data}, AW+NUBITS bits. With NUIOOU==1 the stored addr is 0, never X.
- push = out_en at a rising edge. pop = o_valid & o_ready at a rising edge.
- Write path, evaluated at each rising edge:
  - Bypass: push while the FIFO is empty and (output stage empty or pop) loads the output stage directly. o_valid rises the edge after out_en (1-cycle latency).
  - Otherwise push writes the FIFO tail.
- Pop path: on pop, the output stage reloads from the FIFO head if non-empty, else from bypass if push, else o_valid falls.
- Continuous flow: back-to-back pushes with o_ready held at 1 sustain 1 entry/cycle with no bubbles.
- Stream rules:
  - o_addr/o_data are stable while o_valid=1 and o_ready=0.
  - o_valid never drops without a pop.
  - o_ready is don't-care while o_valid=0.
- Order: entries leave in exact push order. Per-address ordering is implied.
- level:
  - +1 on an accepted push without pop; -1 on pop without push; unchanged on both or neither.
  - Updated at the same edge as the data movement.
- Full and overflow:
  - full is combinational from level.
  - Push while full and no pop: write dropped, level unchanged, ovf set to 1.
  - Push while full with pop: accepted.
- ovf:
  - Set has priority over ovf_clr in the same cycle.
  - Otherwise ovf_clr=1 clears it at the edge.
- FIFO pointers: log2(FDEPTH) bits, wrap naturally modulo FDEPTH. Empty/full are derived from an internal count, not pointer equality.
- Storage: no read-during-write hazard. A head read and a tail write to the same slot cannot occur because bypass covers the empty case.
- Outputs: all registered except full.

Decomposition:
- Shared include header holds the AW computation macro and the entry-width constant, so the core and peripherals agree.
- One sub-module, fifo_sync:
  - Parameterised width/depth.
  - Signals: wr, rd, din, dout, count, empty, full.
  - Async reset.
  - Head-fall-through read (dout = mem[rd_ptr]).
- io_out_buf adds the output stage, bypass, occupancy and overflow logic around fifo_sync.

Test Plan:
- Single write: out_en=1 for 1 cycle, addr_out=3, data_out=32'h0000_1234, o_ready=1.
  → Next cycle o_valid=1, o_addr=3, o_data=32'h1234; one cycle later o_valid=0, level back to 0.
- Back-pressure: 5 writes (data 1..5, addr 0..4) with o_ready=0.
  → level=5, o_data=1 held stable; then o_ready=1 → 1,2,3,4,5 out in order on consecutive cycles.
- Overflow: o_ready=0, 10 writes (data 10..19) with FDEPTH=8.
  → full after the 9th, 10th dropped, ovf=1; drained sequence is 10..18.
  → ovf_clr pulse clears ovf; ovf_clr coincident with a dropped write leaves ovf=1.
- Full plus simultaneous pop: at full, out_en=1 and o_ready=1 in the same cycle.
  → Write accepted, level stays 9, ovf stays 0.
- Reset mid-stream: 4 entries queued, rst pulsed asynchronously between edges.
  → Immediately o_valid=0, level=0; a following write of data 32'hA5 emerges alone.
- NUIOOU=1 build: writes with addr_out=X.
  → o_addr=0 and no X on any output.

Source files
------------

// File: rtl/io_out_buf_pkg.sv
// -----------------------------------------------------------------------------
// io_out_buf_pkg
// Shared width helpers for the core OUT port and its downstream peripherals.
// Both sides compute the address width and the stored entry width from the same
// functions, so a change to NUIOOU or NUBITS cannot leave them disagreeing.
// -----------------------------------------------------------------------------
package io_out_buf_pkg;

  // Address width for a given number of output addresses. A single-address
  // build still carries one address bit, tied to zero.
  function automatic int calc_aw(input int nuioou);
    return (nuioou > 1) ? $clog2(nuioou) : 1;
  endfunction

  // One buffered entry is {addr, data}.
  function automatic int calc_entry_w(input int nuioou, input int nubits);
    return calc_aw(nuioou) + nubits;
  endfunction

endpackage

// File: rtl/io_out_buf_fifo_sync.sv
// -----------------------------------------------------------------------------
// fifo_sync
// Synchronous FIFO with head-fall-through read (dout always shows the head).
// Ports:
//   clk, rst   clock, asynchronous active-high reset (pointers and count only)
//   wr, din    write din at the tail on a rising edge
//   rd         drop the head on a rising edge
//   dout       current head entry (meaningless while empty)
//   count      entries held, 0..DEPTH
//   empty/full derived from count, not from pointer equality
// The caller never writes while full without a read, and never reads while
// empty. A simultaneous read and write while full reuses the head slot; the
// head is read combinationally before the edge, so there is no hazard.
// -----------------------------------------------------------------------------
module fifo_sync #(
  parameter  int W     = 8,
  parameter  int DEPTH = 8,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic          rd,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Pointers are log2(DEPTH) bits; DEPTH is a power of two so they wrap
  // naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr) wr_ptr_d = wr_ptr_q + PW'(1);
    if (rd) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({wr, rd})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage has no reset; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/io_out_buf.sv
// -----------------------------------------------------------------------------
// io_out_buf
// Buffers every OUT write from the processor core and replays it to external
// peripherals over a valid/ready stream. The core cannot stall, so a write that
// arrives with no room is dropped and flagged in a sticky overflow bit.
//
// Stream handshake: an entry transfers on a rising edge where o_valid and
// o_ready are both 1. While o_valid=1 and o_ready=0, o_addr/o_data hold
// steady; o_valid only falls after a transfer; o_ready is ignored while
// o_valid=0.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   out_en, addr_out,     core OUT strobe, address and data (one write per
//   data_out              high cycle)
//   o_valid, o_ready,     output stream
//   o_addr, o_data
//   level                 entries held (FIFO + output stage), 0..FDEPTH+1
//   full                  level == FDEPTH+1 (combinational from level)
//   ovf, ovf_clr          sticky overflow flag and its synchronous clear
//
// Structure: an output register stage in front of fifo_sync. A write that
// finds the FIFO empty and the output stage free (or leaving this cycle) goes
// straight into the output stage, giving one cycle of latency and full
// throughput with o_ready held high.
// -----------------------------------------------------------------------------
module io_out_buf
  import io_out_buf_pkg::*;
#(
  parameter  int NUBITS = 32,
  parameter  int NUIOOU = 8,
  parameter  int FDEPTH = 8,
  localparam int AW     = calc_aw(NUIOOU),
  localparam int LW     = $clog2(FDEPTH + 2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              out_en,
  input  logic [AW-1:0]     addr_out,
  input  logic [NUBITS-1:0] data_out,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [AW-1:0]     o_addr,
  output logic [NUBITS-1:0] o_data,
  output logic [LW-1:0]     level,
  output logic              full,
  output logic              ovf,
  input  logic              ovf_clr
);

  localparam int EW = calc_entry_w(NUIOOU, NUBITS);
  localparam int CW = $clog2(FDEPTH + 1);

  logic [AW-1:0]     addr_in;
  logic [EW-1:0]     in_entry;
  logic [EW-1:0]     fifo_dout;
  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic              fifo_wr;
  logic              fifo_rd;

  logic              push, pop, accept, bypass;

  logic              o_valid_q, o_valid_d;
  logic [AW-1:0]     o_addr_q, o_addr_d;
  logic [NUBITS-1:0] o_data_q, o_data_d;
  logic [LW-1:0]     level_q, level_d;
  logic              ovf_q, ovf_d;

  // A single-address build stores address 0 regardless of what the core
  // drives, so nothing undefined ever reaches the stream.
  assign addr_in  = (NUIOOU > 1) ? addr_out : '0;
  assign in_entry = {addr_in, data_out};

  assign push = out_en;
  assign pop  = o_valid_q & o_ready;

  // With the FIFO full the output stage is necessarily occupied, so the
  // whole buffer is full; a write only fits if the output stage drains now.
  assign accept = push & ~(fifo_full & ~pop);

  // Bypass only when nothing is queued ahead of this write.
  assign bypass  = accept & fifo_empty & (~o_valid_q | pop);
  assign fifo_wr = accept & ~bypass;
  assign fifo_rd = pop & (fifo_count != '0);

  always_comb begin
    o_valid_d = o_valid_q;
    o_addr_d  = o_addr_q;
    o_data_d  = o_data_q;
    if (fifo_rd) begin
      o_valid_d = 1'b1;
      {o_addr_d, o_data_d} = fifo_dout;
    end else if (bypass) begin
      o_valid_d = 1'b1;
      o_addr_d  = addr_in;
      o_data_d  = data_out;
    end else if (pop) begin
      o_valid_d = 1'b0;
    end
  end

  always_comb begin
    level_d = level_q;
    if (accept && !pop)      level_d = level_q + LW'(1);
    else if (pop && !accept) level_d = level_q - LW'(1);
  end

  // A dropped write wins over a clear in the same cycle so it is never lost.
  always_comb begin
    ovf_d = ovf_q;
    if (push && !accept) ovf_d = 1'b1;
    else if (ovf_clr)    ovf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid_q <= 1'b0;
      o_addr_q  <= '0;
      o_data_q  <= '0;
      level_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      o_valid_q <= o_valid_d;
      o_addr_q  <= o_addr_d;
      o_data_q  <= o_data_d;
      level_q   <= level_d;
      ovf_q     <= ovf_d;
    end
  end

  fifo_sync #(
    .W     (EW),
    .DEPTH (FDEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr    (fifo_wr),
    .rd    (fifo_rd),
    .din   (in_entry),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign o_valid = o_valid_q;
  assign o_addr  = o_addr_q;
  assign o_data  = o_data_q;
  assign level   = level_q;
  assign full    = (level_q == LW'(FDEPTH + 1));
  assign ovf     = ovf_q;

endmodule
